panda_if_prefetch: RTL

Parametrised instruction-fetch stage with a request/grant/rvalid memory handshake, a Depth-entry prefetch FIFO and pipelined outstanding requests. It sits between instruction memory and the ID stage and replaces a single-cycle, always-ready fetch. Branch and jump redirects flush the FIFO and discard in-flight responses. Instructions are delivered to ID with a valid/ready handshake.

---
 rtl/panda_if_prefetch_if.sv | 29 ++
 rtl/panda_if_prefetch.sv | 88 ++++++++
 2 files changed

// File: rtl/panda_if_prefetch_if.sv
// panda_if_prefetch_if: fetch-stage bundle of the instruction memory handshake and the ID-side valid/ready handshake
interface panda_if_prefetch_if #(
  parameter int Width = 32
) ();
  logic             instr_req_o;
  logic [Width-1:0] instr_addr_o;
  logic             instr_gnt_i;
  logic             instr_rvalid_i;
  logic [Width-1:0] instr_rdata_i;
  logic             branch_i;
  logic             jump_i;
  logic [Width-1:0] branch_target_i;
  logic [Width-1:0] jump_target_i;
  logic             ready_i;
  logic             valid_o;
  logic [Width-1:0] instr_o;
  logic [Width-1:0] pc_o;
  logic [Width-1:0] pc_inc_o;
  modport master (
    output instr_req_o, instr_addr_o, valid_o, instr_o, pc_o, pc_inc_o,
    input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, branch_i, jump_i,
           branch_target_i, jump_target_i, ready_i
  );
  modport slave (
    input  instr_req_o, instr_addr_o, valid_o, instr_o, pc_o, pc_inc_o,
    output instr_gnt_i, instr_rvalid_i, instr_rdata_i, branch_i, jump_i,
           branch_target_i, jump_target_i, ready_i
  );
endinterface

// File: rtl/panda_if_prefetch.sv
// panda_if_prefetch: instruction fetch with pipelined requests, prefetch FIFO and redirect flush
module panda_if_prefetch #(
  parameter int               Width    = 32,
  parameter int               Depth    = 2,
  parameter logic [Width-1:0] BootAddr = '0
) (
  input logic               clk_i,
  input logic               rst_i,
  panda_if_prefetch_if.master bus
);
  localparam int CW = $clog2(Depth + 1);
  localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PW-1:0]    LAST = PW'(Depth - 1);
  localparam logic [CW-1:0]    DMAX = CW'(Depth);
  localparam logic [Width-1:0] FOUR = Width'(4);
  logic [Width-1:0] fetch_pc;
  logic [Width-1:0] resp_pc;
  logic [Width-1:0] fifo_instr [Depth];
  logic [Width-1:0] fifo_pc    [Depth];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    discard;
  logic [CW-1:0]    in_flight;
  logic [Width-1:0] target_raw;
  logic [Width-1:0] target;
  logic             redirect;
  logic             grant;
  logic             push;
  logic             pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction
  // Handshake decode; the request budget counts buffered plus in-flight fetches so a response always has room
  always_comb begin
    redirect            = bus.jump_i || bus.branch_i;
    target_raw          = bus.jump_i ? bus.jump_target_i : bus.branch_target_i;
    target              = {target_raw[Width-1:2], 2'b00};
    bus.instr_req_o     = !rst_i && ({1'b0, count} + {1'b0, outstanding} < {1'b0, DMAX});
    bus.instr_addr_o    = fetch_pc;
    grant               = bus.instr_req_o && bus.instr_gnt_i;
    in_flight           = outstanding + CW'(grant) - CW'(bus.instr_rvalid_i);
    push                = bus.instr_rvalid_i && (discard == '0) && !redirect;
    bus.valid_o         = (count != '0) && !redirect;
    pop                 = bus.valid_o && bus.ready_i;
    bus.instr_o         = fifo_instr[rd_ptr];
    bus.pc_o            = fifo_pc[rd_ptr];
    bus.pc_inc_o        = fifo_pc[rd_ptr] + FOUR;
  end
  // Fetch PC, FIFO and counters; a redirect flushes the FIFO and marks every in-flight response for discard
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc    <= BootAddr;
      resp_pc     <= BootAddr;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      for (int i = 0; i < Depth; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else begin
      outstanding <= in_flight;
      if (redirect) begin
        fetch_pc <= target;
        resp_pc  <= target;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        discard  <= in_flight;
      end else begin
        if (grant) fetch_pc <= fetch_pc + FOUR;
        if (bus.instr_rvalid_i && discard != '0) discard <= discard - CW'(1);
        if (push) begin
          fifo_instr[wr_ptr] <= bus.instr_rdata_i;
          fifo_pc[wr_ptr]    <= resp_pc;
          wr_ptr             <= nxt(wr_ptr);
          resp_pc            <= resp_pc + FOUR;
        end
        if (pop) rd_ptr <= nxt(rd_ptr);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule
